// File: rtl/ddr3_burst_arbiter.sv
// ddr3_burst_arbiter: round-robin scheduler of fixed-length MIG write/read bursts with ping-pong frame banks
module ddr3_burst_arbiter #(
  parameter int P_BURST_LEN = 80,
  parameter int P_ADDR_STEP = 8,
  parameter int P_FRAME_BURSTS = 480,
  parameter logic [27:0] P_BANK_SPAN = 28'h0800000,
  parameter int P_WR_THRESH = 80,
  parameter int P_RD_THRESH = 500
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_calib_done,
  input  logic [8:0]  i_wr_level,
  input  logic [9:0]  i_rd_level,
  input  logic        i_wr_frame_start,
  input  logic        i_rd_frame_start,
  input  logic        i_app_rdy,
  input  logic        i_app_wdf_rdy,
  output logic        o_app_en,
  output logic [2:0]  o_app_cmd,
  output logic [27:0] o_app_addr,
  output logic        o_app_wdf_wren,
  output logic        o_app_wdf_end,
  output logic        o_wrfifo_rden,
  output logic        o_wr_bank,
  output logic        o_rd_bank,
  output logic        o_busy
);
  localparam logic [7:0]  BL    = 8'(P_BURST_LEN);
  localparam logic [22:0] STEP  = 23'(P_ADDR_STEP);
  localparam logic [8:0]  FB    = 9'(P_FRAME_BURSTS - 1);
  localparam logic [8:0]  WR_TH = 9'(P_WR_THRESH);
  localparam logic [9:0]  RD_TH = 10'(P_RD_THRESH);
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_WRITE, S_READ, S_DONE} state_t;
  state_t state, state_nx;
  logic [7:0] cmd_cnt, dat_cnt;
  logic [8:0] wr_bursts, rd_bursts;
  logic [22:0] wr_off, rd_off;
  logic done_bank, frame_valid, wr_pend, rd_pend, app_en, wdf_wren;
  logic rd_sel, cmd_hs, dat_hs, wr_req, rd_req, go_wr, go_rd, enter;
  logic wr_wrap, rd_wrap, wr_clr, rd_clr;
  // app_cmd doubles as the last-grant record: bit 0 set means read was granted last
  assign rd_sel = o_app_cmd[0];
  assign cmd_hs = app_en & i_app_rdy;
  assign dat_hs = wdf_wren & i_app_wdf_rdy;
  assign wr_req = i_wr_level >= WR_TH;
  assign rd_req = frame_valid & (i_rd_level < RD_TH);
  assign go_wr = wr_req & (~rd_req | rd_sel);
  assign go_rd = rd_req & (~wr_req | ~rd_sel);
  assign enter = (state == S_IDLE) & i_calib_done & (go_wr | go_rd);
  assign wr_wrap = (state == S_DONE) & ~rd_sel & (wr_bursts == FB);
  assign rd_wrap = (state == S_DONE) & rd_sel & (rd_bursts == FB);
  assign wr_clr = (i_wr_frame_start & (state != S_WRITE)) | ((state == S_DONE) & wr_pend);
  assign rd_clr = (i_rd_frame_start & (state != S_READ)) | ((state == S_DONE) & rd_pend);
  assign o_app_en = app_en;
  assign o_app_wdf_wren = wdf_wren;
  assign o_app_wdf_end = wdf_wren;
  assign o_wrfifo_rden = dat_hs;
  assign o_app_addr = rd_sel ? (o_rd_bank ? P_BANK_SPAN : 28'd0) + {5'd0, rd_off}
                             : (o_wr_bank ? P_BANK_SPAN : 28'd0) + {5'd0, wr_off};
  always_ff @(posedge i_clk)
    if (i_rst) state <= S_INIT;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    o_busy = 1'b0;
    case (state)
      S_INIT:  state_nx = i_calib_done ? S_IDLE : S_INIT;
      S_IDLE:  state_nx = !i_calib_done ? S_INIT : go_wr ? S_WRITE : go_rd ? S_READ : S_IDLE;
      S_WRITE: begin
        o_busy = 1'b1;
        state_nx = (cmd_cnt == BL && dat_cnt == BL) ? S_DONE : S_WRITE;
      end
      S_READ:  begin
        o_busy = 1'b1;
        state_nx = (cmd_cnt == BL) ? S_DONE : S_READ;
      end
      S_DONE:  state_nx = i_calib_done ? S_IDLE : S_INIT;
      default: state_nx = S_INIT;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      app_en <= 1'b0;
      wdf_wren <= 1'b0;
      o_app_cmd <= 3'b001;
      cmd_cnt <= '0;
      dat_cnt <= '0;
      wr_off <= '0;
      rd_off <= '0;
      wr_bursts <= '0;
      rd_bursts <= '0;
      o_wr_bank <= 1'b0;
      o_rd_bank <= 1'b0;
      done_bank <= 1'b0;
      frame_valid <= 1'b0;
      wr_pend <= 1'b0;
      rd_pend <= 1'b0;
    end else begin
      if (enter) begin
        app_en <= 1'b1;
        wdf_wren <= go_wr;
        o_app_cmd <= {2'b00, ~go_wr};
        cmd_cnt <= '0;
        dat_cnt <= '0;
      end
      if (cmd_hs) begin
        cmd_cnt <= cmd_cnt + 8'd1;
        if (cmd_cnt == BL - 8'd1) app_en <= 1'b0;
        if (rd_sel) rd_off <= rd_off + STEP;
        else wr_off <= wr_off + STEP;
      end
      if (dat_hs) begin
        dat_cnt <= dat_cnt + 8'd1;
        if (dat_cnt == BL - 8'd1) wdf_wren <= 1'b0;
      end
      if (state == S_DONE && !rd_sel) wr_bursts <= wr_wrap ? 9'd0 : wr_bursts + 9'd1;
      if (wr_wrap) begin
        wr_off <= '0;
        o_wr_bank <= ~o_wr_bank;
        done_bank <= o_wr_bank;
        frame_valid <= 1'b1;
      end
      if (wr_clr) begin
        wr_off <= '0;
        wr_bursts <= '0;
      end
      wr_pend <= (state == S_WRITE) & (wr_pend | i_wr_frame_start);
      if (state == S_DONE && rd_sel) rd_bursts <= rd_wrap ? 9'd0 : rd_bursts + 9'd1;
      if (rd_wrap) begin
        rd_off <= '0;
        o_rd_bank <= done_bank;
      end
      if (rd_clr) begin
        rd_off <= '0;
        rd_bursts <= '0;
        o_rd_bank <= done_bank;
      end
      rd_pend <= (state == S_READ) & (rd_pend | i_rd_frame_start);
    end
  end
endmodule
